// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
//
// Adds two packed-BCD operands one decimal digit per clock, least significant
// digit first. A request is accepted only while idle; the operands and carry-in
// are captured at that point, so later port changes do not affect the
// operation in progress. The partial result builds up in place on 'sum' while
// busy. An operand digit above 9 produces 4'hF in that position, breaks the
// carry chain there, and raises a sticky 'err'.
//
// Parameters
//   DIGITS  number of BCD digits per operand (1..16)
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   begin an addition (honoured only when idle)
//   a, b    packed BCD operands, digit 0 in bits [3:0]
//   cin     carry into digit 0
//   sum     registered BCD result, same packing as a
//   cout    registered decimal carry out of the top digit
//   busy    high while digits are being processed
//   done    one-cycle pulse; sum/cout/err are valid
//   err     set if any operand digit of the current operation exceeded 9
// -----------------------------------------------------------------------------
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t              state;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                carry;
    logic [IDX_W-1:0]    idx;

    // Bit offset of the digit currently being processed.
    logic [IDX_W+1:0]    base;
    logic [3:0]          dig_a;
    logic [3:0]          dig_b;
    logic [3:0]          dig_sum;
    logic [4:0]          t;
    logic                invalid;
    logic                carry_next;

    // One-digit decimal adder on the captured operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        dig_sum    = '0;
        carry_next = 1'b0;

        base    = {idx, 2'b00};
        dig_a   = a_q[base +: 4];
        dig_b   = b_q[base +: 4];
        t       = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry};
        invalid = (dig_a > 4'd9) || (dig_b > 4'd9);

        if (invalid) begin
            dig_sum    = 4'hF;
            carry_next = 1'b0;
        end else if (t > 5'd9) begin
            // t is at most 19, so adding 6 and dropping bit 4 yields t-10.
            dig_sum    = t[3:0] + 4'd6;
            carry_next = 1'b1;
        end else begin
            dig_sum    = t[3:0];
            carry_next = 1'b0;
        end
    end

    // NOTE: the operand registers are deliberately left out of reset: they are
    // always loaded on acceptance before anything reads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end

                ADD: begin
                    sum[base +: 4] <= dig_sum;
                    carry          <= carry_next;
                    if (invalid) begin
                        err <= 1'b1;
                    end
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Directed and randomized bench for bcd_serial_adder (DIGITS=4). Expected
// results come from a reference model that adds the operands as decimal
// integers when all digits are valid, and applies the per-digit invalid-digit
// rule otherwise. Outputs are sampled on the falling edge; inputs are driven
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cin   = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: decimal integer addition for valid operands; digit rule
    // with carry-chain break when any digit is above 9.
    function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                    output logic [W-1:0] s, output logic co, output logic e);
        bit      ok = 1'b1;
        longint  dx = 0;
        longint  dy = 0;
        longint  total;
        longint  limit = 1;
        int      cy;
        int      t;
        s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (x[4*k +: 4] > 4'd9 || y[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        if (ok) begin
            for (int k = DIGITS - 1; k >= 0; k--) begin
                dx = dx * 10 + longint'(x[4*k +: 4]);
                dy = dy * 10 + longint'(y[4*k +: 4]);
                limit = limit * 10;
            end
            total = dx + dy + longint'(c);
            co    = (total >= limit);
            total = total % limit;
            for (int k = 0; k < DIGITS; k++) begin
                s[4*k +: 4] = 4'(total % 10);
                total       = total / 10;
            end
            e = 1'b0;
        end else begin
            cy = int'(c);
            e  = 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                if (x[4*k +: 4] > 4'd9 || y[4*k +: 4] > 4'd9) begin
                    s[4*k +: 4] = 4'hF;
                    cy          = 0;
                    e           = 1'b1;
                end else begin
                    t = int'(x[4*k +: 4]) + int'(y[4*k +: 4]) + cy;
                    if (t > 9) begin
                        s[4*k +: 4] = 4'(t - 10);
                        cy          = 1;
                    end else begin
                        s[4*k +: 4] = 4'(t);
                        cy          = 0;
                    end
                end
            end
            co = cy[0];
        end
    endfunction

    function automatic logic [W-1:0] low_mask(input int k);
        logic [W-1:0] m = '0;
        for (int j = 0; j < k; j++) m[4*j +: 4] = 4'hF;
        return m;
    endfunction

    // One full operation from an idle DUT, checking latency, partial sums and
    // the final result.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input string tag);
        logic [W-1:0] es;
        logic         eco;
        logic         ee;
        ref_add(x, y, c, es, eco, ee);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after accept"}, W'(busy), W'(1));
        check({tag, " sum cleared"}, sum, '0);
        check({tag, " err cleared"}, W'(err), W'(0));
        for (int k = 1; k <= DIGITS; k++) begin
            @(negedge clk);
            check($sformatf("%s partial sum %0d", tag, k), sum, es & low_mask(k));
            if (k < DIGITS) begin
                check($sformatf("%s no early done %0d", tag, k), W'(done), W'(0));
            end
        end
        check({tag, " done"}, W'(done), W'(1));
        check({tag, " busy low in done"}, W'(busy), W'(0));
        check({tag, " cout"}, W'(cout), W'(eco));
        check({tag, " err"}, W'(err), W'(ee));
        @(negedge clk);
        check({tag, " done one cycle"}, W'(done), W'(0));
        check({tag, " sum held"}, sum, es);
    endtask

    initial begin : stim
        int           done_cnt;
        int           first_done;
        int           second_done;
        logic [W-1:0] done_sum;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset, with start asserted to confirm reset priority.
        start = 1'b1;
        a     = 16'h1234;
        repeat (2) @(negedge clk);
        check("reset sum", sum, '0);
        check("reset cout", W'(cout), W'(0));
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset err", W'(err), W'(0));
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", W'(busy), W'(0));

        // Directed vectors.
        run_op(16'h1234, 16'h5678, 1'b0, "d1234p5678");
        run_op(16'h9999, 16'h0001, 1'b0, "d9999p0001");
        run_op(16'h9999, 16'h9999, 1'b1, "d9999p9999c");
        run_op(16'h12A4, 16'h0000, 1'b0, "dinvalid");
        run_op(16'h0005, 16'h0004, 1'b0, "derr_clear");
        run_op(16'h0000, 16'h0000, 1'b0, "dzero");

        // Start re-asserted with new operands during the second ADD cycle.
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        done_sum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_sum = sum;
            end
        end
        check("ignored start single done", W'(done_cnt), W'(1));
        check("ignored start result", done_sum, 16'h6912);
        check("ignored start idle", W'(busy), W'(0));

        // Reset asserted for the third ADD edge aborts the operation.
        @(negedge clk);
        a = 16'h999A; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort sum", sum, '0);
        check("abort cout", W'(cout), W'(0));
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort err", W'(err), W'(0));
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort no done", W'(done_cnt), W'(0));
        run_op(16'h4321, 16'h5678, 1'b1, "after_abort");

        // Start held high: one accepted operation every DIGITS+2 cycles.
        @(negedge clk);
        a = 16'h0999; b = 16'h0001; cin = 1'b0; start = 1'b1;
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 3 * (DIGITS + 2) + 1; i++) begin
            @(negedge clk);
            if (done) begin
                if (done_cnt == 0) first_done = i;
                if (done_cnt == 1) second_done = i;
                done_cnt++;
                check($sformatf("b2b sum %0d", done_cnt), sum, 16'h1000);
            end
        end
        start = 1'b0;
        check("b2b done count", W'(done_cnt), W'(3));
        check("b2b period", W'(second_done - first_done), W'(DIGITS + 2));
        repeat (DIGITS + 3) @(negedge clk);

        // Exhaustive single-digit sweep.
        for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op(W'(x), W'(y), c[0], $sformatf("sweep %0d+%0d+%0d", x, y, c));
                end
            end
        end

        // Randomized operands: mostly valid BCD, some raw nibbles.
        for (int n = 0; n < 40; n++) begin
            if (n % 4 == 3) begin
                ra = W'($urandom);
                rb = W'($urandom);
            end else begin
                for (int k = 0; k < DIGITS; k++) begin
                    ra[4*k +: 4] = 4'($urandom_range(0, 9));
                    rb[4*k +: 4] = 4'($urandom_range(0, 9));
                end
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand %0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin an addition; honoured only in IDLE.
REQ-005 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*DIGITS  operand B, packed BCD, same packing as a.
REQ-007 cin  input  1  carry into digit 0.
REQ-008 sum  output  4*DIGITS  registered BCD result, same packing as a.
REQ-009 cout  output  1  registered decimal carry out of the most significant digit.
REQ-010 busy  output  1  high while an addition is in progress.
REQ-011 done  output  1  one-cycle pulse; sum/cout/err valid.
REQ-012 err  output  1  registered; set if any operand digit of the current operation exceeds 9.

Function
REQ-013 FSM SHALL have states IDLE, ADD, DONE; encoding free.
REQ-014 IDLE: start=1 at an edge -> capture a, b, cin; clear digit index, err, sum, cout; go to ADD.
REQ-015 IDLE: start=0 -> remain; sum, cout, err hold last values.
REQ-016 ADD: each edge processes exactly one digit k, starting at k=0 and rising to k=DIGITS-1, using the captured operands, never the live ports.
REQ-017 Digit rule: t = a_k + b_k + carry (5 bits); if t > 9 then digit = t+6 mod 16, carry = 1, else digit = t, carry = 0.
REQ-018 Invalid digit (a_k > 9 or b_k > 9): digit = 4'hF, carry out of that digit = 0, err set and held sticky until the next accepted start.
REQ-019 After digit DIGITS-1 is processed: cout = final carry; go to DONE.
REQ-020 DONE lasts exactly one cycle: done=1, busy=0; next edge -> IDLE unconditionally.
REQ-021 busy=1 in ADD only; done=1 in DONE only.
REQ-022 Latency: start accepted at edge E0 -> done high in the cycle after edge E(DIGITS); total DIGITS+1 edges from acceptance to done.
REQ-023 start asserted in ADD or DONE SHALL be ignored, not queued; operand/cin changes during ADD have no effect.
REQ-024 Back-to-back: start held high continuously yields one accepted operation per DIGITS+2 cycles.
REQ-025 The carry register is internal; the partial sum is visible on sum during ADD, with digits not yet processed reading 0.

Reset
REQ-026 rst_n=0 at an edge -> state IDLE; sum=0, cout=0, busy=0, done=0, err=0; digit index and carry cleared.
REQ-027 Reset SHALL take priority over start and SHALL abort an operation in ADD or DONE with no done pulse.
REQ-028 After rst_n returns high, the first edge with start=1 is accepted normally.

Verification (DIGITS=4)
REQ-029 a=0x1234, b=0x5678, cin=0, pulse start -> after 5 edges: done=1, sum=0x6912, cout=0, err=0.
REQ-030 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-031 a=0x12A4, b=0x0000, cin=0 -> sum=0x12F4, cout=0, err=1; next valid operation clears err.
REQ-032 start pulsed again at the 2nd ADD cycle, with a/b changed -> ignored; the result matches the first operands; exactly one done pulse.
REQ-033 rst_n=0 for one edge at the 3rd ADD cycle -> all outputs 0, no done; a new start then completes correctly.
REQ-034 Exhaustive single-digit sweep: all a_0, b_0 in 0..15 and cin in {0,1}, with upper digits 0, checked against a reference model.
